// File: rtl/icache_refill_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_ctrl_pkg
// Description : Shared widths, transfer records and state encoding for the
//               instruction-cache line refill controller.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_refill_ctrl_pkg;

  // Default cache geometry; the controller parameters take these as defaults
  localparam int ICACHE_PLEN            = 56;
  localparam int ICACHE_LINE_WIDTH      = 128;
  localparam int ICACHE_MEM_DATA_WIDTH  = 32;
  localparam int ICACHE_SET_ASSOC       = 4;
  localparam int ICACHE_INDEX_WIDTH     = 12;
  localparam int ICACHE_FETCH_WIDTH     = 32;
  localparam int ICACHE_REFILL_BEATS    = ICACHE_LINE_WIDTH / ICACHE_MEM_DATA_WIDTH;
  localparam int ICACHE_OFFSET_WIDTH    = $clog2(ICACHE_LINE_WIDTH / 8);

  // One memory response beat at the default bus width
  typedef struct packed {
    logic                             rvalid;
    logic [ICACHE_MEM_DATA_WIDTH-1:0] rdata;
  } mem_beat_rsp_t;

  // One tag/data array write at the default geometry
  typedef struct packed {
    logic                                              en;
    logic [ICACHE_INDEX_WIDTH-ICACHE_OFFSET_WIDTH-1:0] idx;
    logic [$clog2(ICACHE_SET_ASSOC)-1:0]               way;
    logic [ICACHE_PLEN-ICACHE_INDEX_WIDTH-1:0]         tag;
    logic [ICACHE_LINE_WIDTH-1:0]                      data;
  } refill_wr_t;

  // Refill sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BEATS = 2'd2,
    ST_WRITE = 2'd3
  } refill_state_e;

  // Beat counter width: enough to index every beat, never narrower than 1
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_ctrl
// Description : Instruction-cache miss/refill controller. Accepts one line
//               miss, fetches the line over a narrower memory bus in
//               LINE_WIDTH/MEM_DATA_WIDTH beats, assembles it and issues a
//               single tag/data array write. A kill lets the bus transaction
//               and array write complete but suppresses done/forward.
//               Optional macro ICACHE_CRIT_WORD_FWD_EN enables early
//               forwarding of the requested fetch word.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int PLEN           = ICACHE_PLEN,
  parameter int LINE_WIDTH     = ICACHE_LINE_WIDTH,
  parameter int MEM_DATA_WIDTH = ICACHE_MEM_DATA_WIDTH,
  parameter int SET_ASSOC      = ICACHE_SET_ASSOC,
  parameter int INDEX_WIDTH    = ICACHE_INDEX_WIDTH,
  parameter int FETCH_WIDTH    = ICACHE_FETCH_WIDTH
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  logic                                           miss_req_i,
  input  logic [PLEN-1:0]                                miss_paddr_i,
  input  logic [$clog2(SET_ASSOC)-1:0]                   miss_way_i,
  output logic                                           miss_ready_o,
  input  logic                                           kill_i,
  output logic                                           mem_req_o,
  output logic [PLEN-1:0]                                mem_paddr_o,
  input  logic                                           mem_gnt_i,
  input  logic                                           mem_rvalid_i,
  input  logic [MEM_DATA_WIDTH-1:0]                      mem_rdata_i,
  output logic                                           wr_en_o,
  output logic [INDEX_WIDTH-$clog2(LINE_WIDTH/8)-1:0]    wr_idx_o,
  output logic [$clog2(SET_ASSOC)-1:0]                   wr_way_o,
  output logic [PLEN-INDEX_WIDTH-1:0]                    wr_tag_o,
  output logic [LINE_WIDTH-1:0]                          wr_data_o,
  output logic                                           done_o,
  output logic                                           fwd_valid_o,
  output logic [FETCH_WIDTH-1:0]                         fwd_data_o
);

  localparam int BEATS        = LINE_WIDTH / MEM_DATA_WIDTH;
  localparam int OFFSET_WIDTH = $clog2(LINE_WIDTH / 8);
  localparam int CNT_WIDTH    = cnt_width(BEATS);
  localparam int BEAT_OFF     = $clog2(MEM_DATA_WIDTH / 8);
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BEATS - 1);

  refill_state_e                  state_q, state_d;
  logic [PLEN-1:0]                paddr_q;
  logic [$clog2(SET_ASSOC)-1:0]   way_q;
  logic [LINE_WIDTH-1:0]          line_q;
  logic [CNT_WIDTH-1:0]           cnt_q;
  logic                           killed_q;
  logic                           write_cyc;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state sequencing: idle -> request -> collect beats -> write
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (miss_req_i) state_d = ST_REQ;
      ST_REQ:   if (mem_gnt_i) state_d = ST_BEATS;
      ST_BEATS: if (mem_rvalid_i && (cnt_q == LAST_BEAT)) state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Miss capture, kill tracking and line assembly (beat 0 at the lowest bits)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      paddr_q  <= '0;
      way_q    <= '0;
      line_q   <= '0;
      cnt_q    <= '0;
      killed_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A kill coinciding with a new miss belongs to nothing in flight
          if (miss_req_i) begin
            paddr_q  <= miss_paddr_i;
            way_q    <= miss_way_i;
            cnt_q    <= '0;
            killed_q <= 1'b0;
          end
        end
        ST_REQ: begin
          if (kill_i) killed_q <= 1'b1;
        end
        ST_BEATS: begin
          if (kill_i) killed_q <= 1'b1;
          if (mem_rvalid_i) begin
            line_q[cnt_q*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= mem_rdata_i;
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
        end
        ST_WRITE: begin
          if (kill_i) killed_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign write_cyc    = (state_q == ST_WRITE);
  assign miss_ready_o = (state_q == ST_IDLE);
  assign mem_req_o    = (state_q == ST_REQ);
  assign mem_paddr_o  = mem_req_o ? {paddr_q[PLEN-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}} : '0;

  assign wr_en_o   = write_cyc;
  assign wr_idx_o  = write_cyc ? paddr_q[INDEX_WIDTH-1:OFFSET_WIDTH] : '0;
  assign wr_tag_o  = write_cyc ? paddr_q[PLEN-1:INDEX_WIDTH]         : '0;
  assign wr_way_o  = write_cyc ? way_q                               : '0;
  assign wr_data_o = write_cyc ? line_q                              : '0;
  // A kill arriving in the write cycle itself still cancels completion
  assign done_o    = write_cyc & ~killed_q & ~kill_i;

`ifdef ICACHE_CRIT_WORD_FWD_EN
  localparam int WORDS     = MEM_DATA_WIDTH / FETCH_WIDTH;
  localparam int WORD_OFF  = $clog2(FETCH_WIDTH / 8);
  localparam int WSEL_W    = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [CNT_WIDTH-1:0]   crit_beat;
  logic [WSEL_W-1:0]      crit_word;
  logic                   fwd_hit;
  logic                   fwd_valid_q;
  logic [FETCH_WIDTH-1:0] fwd_data_q;

  if (BEATS > 1) begin : g_beat_sel
    assign crit_beat = paddr_q[OFFSET_WIDTH-1:BEAT_OFF];
  end else begin : g_beat_single
    assign crit_beat = '0;
  end

  if (WORDS > 1) begin : g_word_sel
    assign crit_word = paddr_q[BEAT_OFF-1:WORD_OFF];
  end else begin : g_word_single
    assign crit_word = '0;
  end

  assign fwd_hit = (state_q == ST_BEATS) && mem_rvalid_i && (cnt_q == crit_beat)
                   && !killed_q && !kill_i;

  // One-cycle forward of the requested fetch word, the cycle after its beat
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fwd_valid_q <= 1'b0;
      fwd_data_q  <= '0;
    end else begin
      fwd_valid_q <= fwd_hit;
      fwd_data_q  <= fwd_hit ? mem_rdata_i[crit_word*FETCH_WIDTH +: FETCH_WIDTH] : '0;
    end
  end

  assign fwd_valid_o = fwd_valid_q;
  assign fwd_data_o  = fwd_data_q;
`else
  // Line-offset address bits only matter to the forward path
  logic unused_offset_bits;
  assign unused_offset_bits = ^paddr_q[OFFSET_WIDTH-1:0] ^ (BEAT_OFF > 0);
  assign fwd_valid_o = 1'b0;
  assign fwd_data_o  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_refill_ctrl
// Description : Scoreboard bench for icache_refill_ctrl: default geometry,
//               a 256-bit line over a 64-bit bus, and a single-beat 128-bit
//               bus. Honours ICACHE_CRIT_WORD_FWD_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_refill_ctrl;

  typedef struct {
    int           inst;
    logic [255:0] data;
    logic [7:0]   idx;
    logic [43:0]  tag;
    logic [1:0]   way;
    logic         done;
    int           cyc;
  } wr_exp_t;

  typedef struct {
    int          inst;
    logic [55:0] pa;
  } pa_exp_t;

  typedef struct {
    int          inst;
    logic [31:0] data;
    int          cyc;
  } fwd_exp_t;

  wr_exp_t  q_wr[$];
  pa_exp_t  q_pa[$];
  fwd_exp_t q_fwd[$];

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;
  int pend  = -1;
  bit fwd_seen = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Shared stimulus, routed to the instance selected by sel
  int           sel = 0;
  logic         miss_req = 1'b0;
  logic [55:0]  miss_paddr = '0;
  logic [1:0]   miss_way = '0;
  logic         kill = 1'b0;
  logic         gnt = 1'b0;
  logic         rvalid = 1'b0;
  logic [127:0] rdata = '0;
  logic [127:0] beat_data [4];

  logic [2:0]   rdy, mreq, wen, dn, fv;
  logic [55:0]  mpa0, mpa1, mpa2;
  logic [7:0]   idx0, idx2;
  logic [6:0]   idx1;
  logic [1:0]   way0, way1, way2;
  logic [43:0]  tag0, tag1, tag2;
  logic [127:0] wd0, wd2;
  logic [255:0] wd1;
  logic [31:0]  fd0, fd1, fd2;

  icache_refill_ctrl u_dut0 (
    .clk_i(clk), .rst_i(rst),
    .miss_req_i(miss_req && sel == 0), .miss_paddr_i(miss_paddr), .miss_way_i(miss_way),
    .miss_ready_o(rdy[0]), .kill_i(kill && sel == 0),
    .mem_req_o(mreq[0]), .mem_paddr_o(mpa0), .mem_gnt_i(gnt && sel == 0),
    .mem_rvalid_i(rvalid && sel == 0), .mem_rdata_i(rdata[31:0]),
    .wr_en_o(wen[0]), .wr_idx_o(idx0), .wr_way_o(way0), .wr_tag_o(tag0), .wr_data_o(wd0),
    .done_o(dn[0]), .fwd_valid_o(fv[0]), .fwd_data_o(fd0)
  );

  icache_refill_ctrl #(.LINE_WIDTH(256), .MEM_DATA_WIDTH(64)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .miss_req_i(miss_req && sel == 1), .miss_paddr_i(miss_paddr), .miss_way_i(miss_way),
    .miss_ready_o(rdy[1]), .kill_i(kill && sel == 1),
    .mem_req_o(mreq[1]), .mem_paddr_o(mpa1), .mem_gnt_i(gnt && sel == 1),
    .mem_rvalid_i(rvalid && sel == 1), .mem_rdata_i(rdata[63:0]),
    .wr_en_o(wen[1]), .wr_idx_o(idx1), .wr_way_o(way1), .wr_tag_o(tag1), .wr_data_o(wd1),
    .done_o(dn[1]), .fwd_valid_o(fv[1]), .fwd_data_o(fd1)
  );

  icache_refill_ctrl #(.MEM_DATA_WIDTH(128)) u_dut2 (
    .clk_i(clk), .rst_i(rst),
    .miss_req_i(miss_req && sel == 2), .miss_paddr_i(miss_paddr), .miss_way_i(miss_way),
    .miss_ready_o(rdy[2]), .kill_i(kill && sel == 2),
    .mem_req_o(mreq[2]), .mem_paddr_o(mpa2), .mem_gnt_i(gnt && sel == 2),
    .mem_rvalid_i(rvalid && sel == 2), .mem_rdata_i(rdata),
    .wr_en_o(wen[2]), .wr_idx_o(idx2), .wr_way_o(way2), .wr_tag_o(tag2), .wr_data_o(wd2),
    .done_o(dn[2]), .fwd_valid_o(fv[2]), .fwd_data_o(fd2)
  );

  function automatic logic [255:0] get_wd(input int k);
    case (k)
      0: return {128'h0, wd0};
      1: return wd1;
      default: return {128'h0, wd2};
    endcase
  endfunction

  function automatic logic [7:0] get_idx(input int k);
    case (k)
      0: return idx0;
      1: return {1'b0, idx1};
      default: return idx2;
    endcase
  endfunction

  function automatic logic [43:0] get_tag(input int k);
    case (k)
      0: return tag0;
      1: return tag1;
      default: return tag2;
    endcase
  endfunction

  function automatic logic [1:0] get_way(input int k);
    case (k)
      0: return way0;
      1: return way1;
      default: return way2;
    endcase
  endfunction

  function automatic logic [55:0] get_mpa(input int k);
    case (k)
      0: return mpa0;
      1: return mpa1;
      default: return mpa2;
    endcase
  endfunction

  function automatic logic [31:0] get_fd(input int k);
    case (k)
      0: return fd0;
      1: return fd1;
      default: return fd2;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: event occurred, none expected", nm);
  endtask

  // Monitor: compares every presented request/write/forward against the queues
  always @(negedge clk) begin
    if (pend >= 0) begin
      chk("ready_after_write", rdy[pend], 1);
      chk("wr_en_single_pulse", wen[pend], 0);
      chk("done_single_pulse", dn[pend], 0);
      pend = -1;
    end
    for (int k = 0; k < 3; k++) begin
      if (mreq[k] && gnt && sel == k) begin
        if (q_pa.size() == 0) fail("unexpected_mem_req");
        else begin
          pa_exp_t e;
          e = q_pa.pop_front();
          chk("mem_paddr", get_mpa(k), e.pa);
          chk("mem_req_inst", k, e.inst);
        end
      end
      if (wen[k]) begin
        if (q_wr.size() == 0) fail("unexpected_wr_en");
        else begin
          wr_exp_t w;
          w = q_wr.pop_front();
          chk("wr_inst", k, w.inst);
          chk("wr_data", get_wd(k), w.data);
          chk("wr_idx", get_idx(k), w.idx);
          chk("wr_tag", get_tag(k), w.tag);
          chk("wr_way", get_way(k), w.way);
          chk("done", dn[k], w.done);
          chk("wr_cycle", cyc, w.cyc);
          chk("ready_low_in_write", rdy[k], 0);
          pend = k;
        end
      end
      if (dn[k] && !wen[k]) fail("done_without_write");
`ifdef ICACHE_CRIT_WORD_FWD_EN
      if (fv[k]) begin
        if (q_fwd.size() == 0) fail("unexpected_fwd_valid");
        else begin
          fwd_exp_t f;
          f = q_fwd.pop_front();
          chk("fwd_inst", k, f.inst);
          chk("fwd_data", get_fd(k), f.data);
          chk("fwd_cycle", cyc, f.cyc);
        end
      end
`else
      if (fv[k] || get_fd(k) != 32'h0) fwd_seen = 1'b1;
`endif
    end
  end

  // Wait for idle, optionally inject stray beats, issue the miss and grant
  task automatic start_miss(input int k, input logic [55:0] pa, input logic [1:0] w,
                            input int gdly, input bit stray, input bit kill_with_miss,
                            input logic [55:0] epa);
    int t = 0;
    sel = k;
    while (!rdy[k] && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!rdy[k]) fail("miss_ready_timeout");
    if (stray) begin
      rvalid = 1'b1; rdata = '1;
      @(posedge clk); #1;
      rvalid = 1'b0;
    end
    q_pa.push_back('{k, epa});
    miss_req = 1'b1; miss_paddr = pa; miss_way = w; kill = kill_with_miss;
    @(posedge clk); #1;
    miss_req = 1'b0; miss_paddr = '0; kill = 1'b0;
    for (int i = 0; i < gdly; i++) begin
      rvalid = stray && (i == 0); rdata = '1;
      @(posedge clk); #1;
      rvalid = 1'b0;
    end
    gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0;
  endtask

  // Drive beats from beat_data; expectations are queued as each beat is driven
  task automatic send_beats(input int k, input int n_total, input int n_send, input int gap,
                            input int kill_at, input int crit, input logic [31:0] efwd,
                            input logic [255:0] eline, input logic [7:0] eidx,
                            input logic [43:0] etag, input logic [1:0] ew);
    for (int i = 0; i < n_send; i++) begin
      rvalid = 1'b1; rdata = beat_data[i]; kill = (i == kill_at);
      if (i == crit && kill_at > crit) q_fwd.push_back('{k, efwd, cyc + 1});
      if (i == n_total - 1)
        q_wr.push_back('{k, eline, eidx, etag, ew, (kill_at >= n_total), cyc + 1});
      @(posedge clk); #1;
      rvalid = 1'b0; kill = 1'b0; rdata = '0;
      if (i < n_send - 1) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", rdy, 3'b111);
    chk("reset_mem_req", mreq, 3'b000);
    chk("reset_wr_en", wen, 3'b000);
    chk("reset_done", dn, 3'b000);
    chk("reset_fwd_valid", fv, 3'b000);
    chk("reset_mem_paddr", mpa0, 56'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic refill, back-to-back beats
    beat_data = '{128'h11111111, 128'h22222222, 128'h33333333, 128'h44444444};
    start_miss(0, 56'h8000_1234, 2'd2, 3, 1'b0, 1'b0, 56'h8000_1230);
    send_beats(0, 4, 4, 0, 99, 1, 32'h22222222,
               256'h44444444_33333333_22222222_11111111, 8'h23, 44'h80001, 2'd2);

    // Gapped beats with stray rvalid in IDLE and REQ
    beat_data = '{128'hA0A0A0A0, 128'hB1B1B1B1, 128'hC2C2C2C2, 128'hD3D3D3D3};
    start_miss(0, 56'h8000_1238, 2'd1, 2, 1'b1, 1'b0, 56'h8000_1230);
    send_beats(0, 4, 4, 2, 99, 2, 32'hC2C2C2C2,
               256'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0, 8'h23, 44'h80001, 2'd1);

    // Kill during beat 1: line still written, no done, no forward
    beat_data = '{128'h01020304, 128'h05060708, 128'h090A0B0C, 128'h0D0E0F10};
    start_miss(0, 56'h5A7C, 2'd3, 0, 1'b0, 1'b0, 56'h5A70);
    send_beats(0, 4, 4, 0, 1, 3, 32'h0D0E0F10,
               256'h0D0E0F10_090A0B0C_05060708_01020304, 8'hA7, 44'h5, 2'd3);

    // Back-to-back miss with kill coincident in IDLE (ignored)
    beat_data = '{128'hCAFEBABE, 128'hDEADBEEF, 128'h0BADF00D, 128'hFEEDFACE};
    start_miss(0, 56'h1_2345_6780, 2'd0, 1, 1'b0, 1'b1, 56'h1_2345_6780);
    send_beats(0, 4, 4, 1, 99, 0, 32'hCAFEBABE,
               256'hFEEDFACE_0BADF00D_DEADBEEF_CAFEBABE, 8'h78, 44'h123456, 2'd0);

    // Reset after beat 2
    beat_data = '{128'h55555555, 128'h66666666, 128'h77777777, 128'h88888888};
    start_miss(0, 56'h8000_1234, 2'd2, 0, 1'b0, 1'b0, 56'h8000_1230);
    send_beats(0, 4, 3, 0, 99, 1, 32'h66666666, '0, 8'h0, 44'h0, 2'd0);
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", rdy[0], 1);
    chk("rst_mid_mem_req", mreq[0], 0);
    chk("rst_mid_wr_en", wen[0], 0);
    chk("rst_mid_done", dn[0], 0);
    chk("rst_mid_mem_paddr", mpa0, 56'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    rvalid = 1'b1; rdata = 128'h99999999;
    @(posedge clk); #1;
    rvalid = 1'b0; rdata = '0;
    chk("late_beat_ready", rdy[0], 1);
    chk("late_beat_mem_req", mreq[0], 0);

    // Refill after reset
    beat_data = '{128'h1, 128'h2, 128'h3, 128'h4};
    start_miss(0, 56'hFF0, 2'd1, 0, 1'b0, 1'b0, 56'hFF0);
    send_beats(0, 4, 4, 0, 99, 0, 32'h1,
               256'h00000004_00000003_00000002_00000001, 8'hFF, 44'h0, 2'd1);

    // 256-bit line over 64-bit bus
    beat_data = '{128'h11111111_22222222, 128'h33333333_44444444,
                  128'h55555555_66666666, 128'h77777777_88888888};
    start_miss(1, 56'h8000_1234, 2'd2, 1, 1'b0, 1'b0, 56'h8000_1220);
    send_beats(1, 4, 4, 1, 99, 2, 32'h55555555,
               256'h77777777_88888888_55555555_66666666_33333333_44444444_11111111_22222222,
               8'h11, 44'h80001, 2'd2);

    // Single-beat 128-bit bus
    beat_data[0] = 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978;
    start_miss(2, 56'h8000_1234, 2'd3, 2, 1'b0, 1'b0, 56'h8000_1230);
    send_beats(2, 1, 1, 0, 99, 0, 32'h0F1E2D3C,
               {128'h0, 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978}, 8'h23, 44'h80001, 2'd3);

    t = 0;
    while ((q_wr.size() != 0 || q_pa.size() != 0) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    @(negedge clk);
    @(negedge clk);
    chk("wr_queue_drained", q_wr.size(), 0);
    chk("paddr_queue_drained", q_pa.size(), 0);
`ifdef ICACHE_CRIT_WORD_FWD_EN
    chk("fwd_queue_drained", q_fwd.size(), 0);
`else
    chk("fwd_tied_off", fwd_seen, 0);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
Parametrised instruction-cache miss/refill controller. Accepts one line-miss request from the icache, fetches the full line over a narrower memory bus in several beats, assembles it and issues a single write into the tag/data arrays. Generalises the single-beat, full-line memory response to any MEM_DATA_WIDTH that divides the line width, and adds kill handling and optional early critical-word forwarding.

Parameters:
PLEN, 56, physical address width
LINE_WIDTH, 128, cache line bits
MEM_DATA_WIDTH, 32, memory beat bits; power of two, >= FETCH_WIDTH, divides LINE_WIDTH
SET_ASSOC, 4, ways
INDEX_WIDTH, 12, index+offset bits
FETCH_WIDTH, 32, fetch word bits (forward path)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
miss_req_i  in  1  miss request valid
miss_paddr_i  in  PLEN  physical address of missing fetch
miss_way_i  in  $clog2(SET_ASSOC)  victim way
miss_ready_o  out  1  controller idle, miss accepted
kill_i  in  1  abort delivery of current refill
mem_req_o  out  1  memory request, held until grant
mem_paddr_o  out  PLEN  line-aligned address
mem_gnt_i  in  1  memory accepted request
mem_rvalid_i  in  1  beat valid
mem_rdata_i  in  MEM_DATA_WIDTH  beat data
wr_en_o  out  1  array write strobe
wr_idx_o  out  INDEX_WIDTH-OFFSET_WIDTH  set index
wr_way_o  out  $clog2(SET_ASSOC)  way
wr_tag_o  out  PLEN-INDEX_WIDTH  tag
wr_data_o  out  LINE_WIDTH  assembled line
done_o  out  1  refill complete, not killed
fwd_valid_o  out  1  critical word valid (feature only)
fwd_data_o  out  FETCH_WIDTH  critical word (feature only)

Behaviour:
- BEATS = LINE_WIDTH/MEM_DATA_WIDTH; OFFSET_WIDTH = $clog2(LINE_WIDTH/8); beat counter $clog2(BEATS) bits, min 1.
- Reset: state IDLE; all outputs 0 except miss_ready_o=1; line buffer, counter, killed flag cleared. Reset mid-refill abandons it; beats still arriving after reset are ignored in IDLE.
- IDLE: miss_ready_o=1. On miss_req_i: latch paddr/way, clear killed, counter=0 -> REQ.
- REQ: mem_req_o=1, mem_paddr_o = paddr with low OFFSET_WIDTH bits zero, stable until mem_gnt_i. Grant -> BEATS next cycle.
- BEATS: each mem_rvalid_i writes mem_rdata_i into line bits [k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH], k=counter (beat 0 = lowest address), counter++. Beat k=BEATS-1 -> WRITE. rvalid outside BEATS ignored.
- WRITE (one cycle): wr_en_o=1 with idx=paddr[INDEX_WIDTH-1:OFFSET_WIDTH], tag=paddr[PLEN-1:INDEX_WIDTH], way, full line; done_o=1 iff killed=0 -> IDLE.
- Latency: accept cycle 0, mem_req_o cycle 1; last beat at cycle b -> wr_en_o cycle b+1, miss_ready_o cycle b+2. Back-to-back: miss_req_i at b+2 accepted.
- kill_i in REQ/BEATS/WRITE sets killed; bus transaction still completes, line still written (data correct), done_o and fwd_valid_o suppressed. kill_i in IDLE no effect; kill_i with miss_req_i in IDLE: miss accepted, kill ignored.
- wr_en_o, done_o, fwd_valid_o are single-cycle pulses.

Optional Feature:
ICACHE_CRIT_WORD_FWD_EN: defined -> the cycle after the beat holding the requested word (beat = paddr[OFFSET_WIDTH-1:$clog2(MEM_DATA_WIDTH/8)]) arrives, fwd_valid_o=1 for one cycle, fwd_data_o = word at paddr[$clog2(MEM_DATA_WIDTH/8)-1:$clog2(FETCH_WIDTH/8)] within that beat; suppressed if killed at or before that beat. Undefined -> fwd_valid_o, fwd_data_o tied 0, no forward logic.

Decomposition:
- ariane_pkg: add ICACHE_MEM_DATA_WIDTH, ICACHE_REFILL_BEATS, mem_beat_rsp_t {rvalid, rdata}, refill_wr_t {en, idx, way, tag, data}; reuse ICACHE_* widths as parameter defaults.
- No sub-module; line assembly buffer inline.

Test Plan:
- miss paddr 0x8000_1234, way 2, gnt cycle 3, beats 0x11111111..0x44444444 back-to-back -> mem_paddr_o=0x8000_1230, wr_data_o=0x44444444_33333333_22222222_11111111, wr_idx_o=0x23, wr_tag_o=0x80001, done_o one cycle.
- beats with 2-cycle gaps and rvalid in IDLE -> gap-insensitive line, stray beat ignored, miss_ready_o low until b+2.
- kill_i during beat 1 -> wr_en_o pulses with correct line, done_o=0, next miss accepted normally.
- rst_i asserted after beat 2 -> all outputs 0, miss_ready_o=1 next edge; late beats ignored; next refill correct.
- MEM_DATA_WIDTH=64, LINE_WIDTH=256 -> 4 beats, correct placement; MEM_DATA_WIDTH=128, LINE_WIDTH=128 -> single beat, wr_en_o cycle after it.
- ICACHE_CRIT_WORD_FWD_EN, paddr offset 0x8, 32-bit bus -> fwd_valid_o cycle after beat 2, fwd_data_o = beat 2 data.
